// File: rtl/spu_fetch_queue_pkg.sv
// Shared types and limits for the SPU instruction fetch queue.
package spu_fetch_queue_pkg;

  typedef enum logic [1:0] {
    FQ_REQ     = 2'd0,
    FQ_WAIT    = 2'd1,
    FQ_DISCARD = 2'd2
  } fq_state_e;

  localparam int FQ_MAX_ISSUE = 4;

  // Widest issue group the decode slot mux is built for, clamped to the architectural limit.
  function automatic int fq_issue_slots(input int issue_w);
    return (issue_w > FQ_MAX_ISSUE) ? FQ_MAX_ISSUE : issue_w;
  endfunction

endpackage

// File: rtl/spu_fetch_queue_line_buf.sv
// Line buffer array for the fetch queue: valid/base/data per entry, one write port,
// and an issue-group read mux that may spill into the following sequential line.
module spu_fq_line_buf
  import spu_fetch_queue_pkg::*;
#(
  parameter int LINE_WD = 1024,
  parameter int INS_WD  = 32,
  parameter int ISSUE_W = 2,
  parameter int NLINES  = 2,
  parameter int ADDR_WD = 32,
  localparam int LINE_INS   = LINE_WD / INS_WD,
  localparam int LINE_BYTES = LINE_WD / 8,
  localparam int OFF_W      = $clog2(LINE_INS),
  localparam int PTR_W      = $clog2(NLINES),
  localparam int CNT_W      = $clog2(ISSUE_W + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        wr_en_i,
  input  logic [PTR_W-1:0]            wr_ptr_i,
  input  logic [ADDR_WD-1:0]          wr_base_i,
  input  logic [LINE_WD-1:0]          wr_data_i,
  input  logic                        free_en_i,
  input  logic [PTR_W-1:0]            free_ptr_i,
  input  logic [PTR_W-1:0]            rd_ptr_i,
  input  logic [OFF_W-1:0]            rd_off_i,
  output logic [NLINES-1:0]           vld_o,
  output logic [CNT_W-1:0]            rd_count_o,
  output logic [ISSUE_W*INS_WD-1:0]   rd_ins_o
);

  localparam int NSLOT = fq_issue_slots(ISSUE_W);

  logic [NLINES-1:0]         vld_q;
  logic [NLINES-1:0]         vld_d;
  logic [ADDR_WD-1:0]        base_q [NLINES];
  logic [LINE_WD-1:0]        data_q [NLINES];
  logic [PTR_W-1:0]          nxt_ptr_s;
  logic                      nxt_ok_s;
  logic [CNT_W-1:0]          rd_count_s;
  logic [ISSUE_W*INS_WD-1:0] rd_ins_s;

  // Valid-bit next state: flush wins, a write and a free never hit the same entry.
  always_comb begin
    vld_d = vld_q;
    for (int n = 0; n < NLINES; n++) begin
      if (clr_i) begin
        vld_d[n] = 1'b0;
      end else if (wr_en_i && (wr_ptr_i == PTR_W'(n))) begin
        vld_d[n] = 1'b1;
      end else if (free_en_i && (free_ptr_i == PTR_W'(n))) begin
        vld_d[n] = 1'b0;
      end else begin
        vld_d[n] = vld_q[n];
      end
    end
  end

  // Valid-bit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Line base address register, captured on fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NLINES; n++) begin
        base_q[n] <= '0;
      end
    end else if (wr_en_i && !clr_i) begin
      base_q[wr_ptr_i] <= wr_base_i;
    end
  end

  // Line data storage; contents are only observed behind the valid bits.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) begin
      data_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign nxt_ptr_s = rd_ptr_i + PTR_W'(1);
  assign nxt_ok_s  = vld_q[nxt_ptr_s] &&
                     (base_q[nxt_ptr_s] == (base_q[rd_ptr_i] + ADDR_WD'(LINE_BYTES)));

  // Issue-group select; the group is truncated at the first slot without a usable word.
  always_comb begin
    logic [OFF_W:0]   idx;
    logic             hit;
    logic             stop;
    logic [LINE_WD-1:0] line;
    rd_count_s = '0;
    rd_ins_s   = '0;
    idx        = '0;
    hit        = 1'b0;
    stop       = 1'b0;
    line       = '0;
    for (int i = 0; i < NSLOT; i++) begin
      idx = {1'b0, rd_off_i} + (OFF_W+1)'(i);
      if (idx[OFF_W]) begin
        hit  = nxt_ok_s;
        line = data_q[nxt_ptr_s];
      end else begin
        hit  = vld_q[rd_ptr_i];
        line = data_q[rd_ptr_i];
      end
      if (hit && !stop) begin
        rd_ins_s[(ISSUE_W-1-i)*INS_WD +: INS_WD] =
          line[(LINE_INS-1-int'(idx[OFF_W-1:0]))*INS_WD +: INS_WD];
        rd_count_s = rd_count_s + CNT_W'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  assign vld_o      = vld_q;
  assign rd_count_o = rd_count_s;
  assign rd_ins_o   = rd_ins_s;

endmodule

// File: rtl/spu_fetch_queue.sv
// SPU instruction fetch queue: line prefetch FSM, PC tracking and ISSUE_W-wide issue to decode.
// Optional performance counters are built when SPU_FQ_PERF_EN is defined.
module spu_fetch_queue
  import spu_fetch_queue_pkg::*;
#(
  parameter int LINE_WD = 1024,
  parameter int INS_WD  = 32,
  parameter int ISSUE_W = 2,
  parameter int NLINES  = 2,
  parameter int ADDR_WD = 32,
  parameter logic [ADDR_WD-1:0] RESET_PC = '0,
  localparam int CNT_W = $clog2(ISSUE_W + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      line_req,
  output logic [ADDR_WD-1:0]        line_addr,
  input  logic                      line_ack,
  input  logic                      line_vld,
  input  logic [LINE_WD-1:0]        line_data,
  input  logic                      redirect,
  input  logic [ADDR_WD-1:0]        redirect_pc,
  input  logic                      dec_stall,
  output logic [CNT_W-1:0]          out_count,
  output logic [ISSUE_W*INS_WD-1:0] out_ins,
  output logic [ADDR_WD-1:0]        out_pc,
  output logic [31:0]               perf_stall,
  output logic [31:0]               perf_empty,
  output logic [31:0]               perf_redir
);

  localparam int LINE_INS   = LINE_WD / INS_WD;
  localparam int LINE_BYTES = LINE_WD / 8;
  localparam int OFF_W      = $clog2(LINE_INS);
  localparam int PTR_W      = $clog2(NLINES);
  localparam logic [ADDR_WD-1:0] LINE_MASK = ~ADDR_WD'(LINE_BYTES - 1);
  localparam logic [ADDR_WD-1:0] WORD_MASK = ~ADDR_WD'(2'd3);

  fq_state_e                 state_q, state_d;
  logic [ADDR_WD-1:0]        pc_q, pc_d;
  logic [ADDR_WD-1:0]        line_addr_q, line_addr_d;
  logic [PTR_W-1:0]          head_q, head_d;
  logic [PTR_W-1:0]          tail_q, tail_d;
  logic                      run_q;
  logic [NLINES-1:0]         vld_s;
  logic [CNT_W-1:0]          count_s;
  logic [ISSUE_W*INS_WD-1:0] ins_s;
  logic [OFF_W-1:0]          head_off_s;
  logic [OFF_W:0]            end_s;
  logic                      consume_s;
  logic                      line_req_s;
  logic                      wr_en_s;
  logic                      free_s;
  logic                      clr_s;

  spu_fq_line_buf #(
    .LINE_WD (LINE_WD),
    .INS_WD  (INS_WD),
    .ISSUE_W (ISSUE_W),
    .NLINES  (NLINES),
    .ADDR_WD (ADDR_WD)
  ) u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_s),
    .wr_en_i    (wr_en_s),
    .wr_ptr_i   (tail_q),
    .wr_base_i  (line_addr_q),
    .wr_data_i  (line_data),
    .free_en_i  (free_s),
    .free_ptr_i (head_q),
    .rd_ptr_i   (head_q),
    .rd_off_i   (head_off_s),
    .vld_o      (vld_s),
    .rd_count_o (count_s),
    .rd_ins_o   (ins_s)
  );

  assign head_off_s = pc_q[OFF_W+1:2];
  assign end_s      = {1'b0, head_off_s} + (OFF_W+1)'(count_s);
  assign consume_s  = (count_s != '0) && !dec_stall;
  // run_q keeps line_req low for the first cycle out of reset.
  assign line_req_s = run_q && (state_q == FQ_REQ) && !vld_s[tail_q];

  // Fetch FSM next state; a redirect overrides the normal transition.
  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    wr_en_s     = 1'b0;
    case (state_q)
      FQ_REQ: begin
        if (line_req_s && line_ack) begin
          state_d = FQ_WAIT;
        end else begin
          state_d = FQ_REQ;
        end
      end
      FQ_WAIT: begin
        if (line_vld) begin
          wr_en_s     = 1'b1;
          line_addr_d = line_addr_q + ADDR_WD'(LINE_BYTES);
          state_d     = FQ_REQ;
        end else begin
          state_d = FQ_WAIT;
        end
      end
      FQ_DISCARD: begin
        if (line_vld) begin
          state_d = FQ_REQ;
        end else begin
          state_d = FQ_DISCARD;
        end
      end
      default: begin
        state_d = FQ_REQ;
      end
    endcase
    if (redirect) begin
      wr_en_s     = 1'b0;
      line_addr_d = redirect_pc & LINE_MASK;
      // A response still owed after this cycle must be swallowed before re-requesting.
      if (state_q == FQ_REQ) begin
        state_d = (line_req_s && line_ack) ? FQ_DISCARD : FQ_REQ;
      end else begin
        state_d = line_vld ? FQ_REQ : FQ_DISCARD;
      end
    end else begin
      state_d = state_d;
    end
  end

  // PC and buffer pointer next state.
  always_comb begin
    pc_d   = pc_q;
    head_d = head_q;
    tail_d = tail_q;
    clr_s  = 1'b0;
    free_s = 1'b0;
    if (redirect) begin
      pc_d   = redirect_pc & WORD_MASK;
      head_d = '0;
      tail_d = '0;
      clr_s  = 1'b1;
    end else begin
      if (consume_s) begin
        pc_d   = pc_q + ADDR_WD'({count_s, 2'b00});
        free_s = end_s[OFF_W];
        head_d = end_s[OFF_W] ? (head_q + PTR_W'(1)) : head_q;
      end else begin
        pc_d = pc_q;
      end
      if (wr_en_s) begin
        tail_d = tail_q + PTR_W'(1);
      end else begin
        tail_d = tail_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FQ_REQ;
      pc_q        <= RESET_PC;
      line_addr_q <= RESET_PC & LINE_MASK;
      head_q      <= '0;
      tail_q      <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      line_addr_q <= line_addr_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      run_q       <= 1'b1;
    end
  end

  assign line_req  = line_req_s;
  assign line_addr = line_addr_q;
  assign out_count = count_s;
  assign out_ins   = ins_s;
  assign out_pc    = pc_q;

`ifdef SPU_FQ_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_empty_q;
  logic [31:0] perf_redir_q;

  // Free-running event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= 32'd0;
      perf_empty_q <= 32'd0;
      perf_redir_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_q + 32'(((count_s != '0) && dec_stall));
      perf_empty_q <= perf_empty_q + 32'(((count_s == '0) && !redirect));
      perf_redir_q <= perf_redir_q + 32'(redirect);
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_empty = perf_empty_q;
  assign perf_redir = perf_redir_q;
`else
  assign perf_stall = 32'd0;
  assign perf_empty = 32'd0;
  assign perf_redir = 32'd0;
`endif

endmodule

// File: tb/tb_spu_fetch_queue.sv
// Directed bench for spu_fetch_queue; line at address A holds word k = A/4 + k.
module tb_spu_fetch_queue;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          line_ack = 1'b0;
  logic          line_vld = 1'b0;
  logic          redirect = 1'b0;
  logic          dec_stall = 1'b0;
  logic [1023:0] line_data = '0;
  logic [31:0]   redirect_pc = '0;
  logic          line_req;
  logic [31:0]   line_addr;
  logic [1:0]    out_count;
  logic [63:0]   out_ins;
  logic [31:0]   out_pc;
  logic [31:0]   perf_stall;
  logic [31:0]   perf_empty;
  logic [31:0]   perf_redir;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef SPU_FQ_PERF_EN
  localparam logic [63:0] PERF_ON = 64'd1;
`else
  localparam logic [63:0] PERF_ON = 64'd0;
`endif

  always #5 clk = ~clk;

  spu_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .line_req    (line_req),
    .line_addr   (line_addr),
    .line_ack    (line_ack),
    .line_vld    (line_vld),
    .line_data   (line_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_stall   (dec_stall),
    .out_count   (out_count),
    .out_ins     (out_ins),
    .out_pc      (out_pc),
    .perf_stall  (perf_stall),
    .perf_empty  (perf_empty),
    .perf_redir  (perf_redir)
  );

  function automatic logic [1023:0] mk_line(input logic [31:0] a);
    logic [1023:0] l;
    l = '0;
    for (int k = 0; k < 32; k++) begin
      l[1023-32*k -: 32] = (a >> 2) + 32'(k);
    end
    return l;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_grp(input string tag, input logic [1:0] cnt, input logic [31:0] pc,
                         input logic [63:0] ins);
    check_eq({tag, "_cnt"}, 64'(out_count), 64'(cnt));
    check_eq({tag, "_pc"},  64'(out_pc),    64'(pc));
    check_eq({tag, "_ins"}, out_ins,        ins);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic fill(input logic [31:0] a);
    line_ack = 1'b1;
    tick;
    line_ack  = 1'b0;
    line_vld  = 1'b1;
    line_data = mk_line(a);
    tick;
    line_vld  = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    check_eq("rst_req",   64'(line_req),   64'd0);
    check_eq("rst_addr",  64'(line_addr),  64'd0);
    check_eq("rst_cnt",   64'(out_count),  64'd0);
    check_eq("rst_ins",   out_ins,         64'd0);
    check_eq("rst_pc",    64'(out_pc),     64'd0);
    check_eq("rst_pstl",  64'(perf_stall), 64'd0);
    check_eq("rst_pemp",  64'(perf_empty), 64'd0);
    check_eq("rst_predir",64'(perf_redir), 64'd0);

    // First line: ack after release, response three cycles after the ack.
    rst = 1'b1;
    tick;
    check_eq("req0",      64'(line_req),  64'd1);
    check_eq("req0_addr", 64'(line_addr), 64'h0);
    line_ack = 1'b1;
    tick;
    line_ack = 1'b0;
    check_eq("wait_noreq", 64'(line_req), 64'd0);
    tick;
    tick;
    line_vld  = 1'b1;
    line_data = mk_line(32'h0);
    tick;
    line_vld = 1'b0;
    chk_grp("g0", 2'd2, 32'h0, {32'd0, 32'd1});
    check_eq("req1",      64'(line_req),  64'd1);
    check_eq("req1_addr", 64'(line_addr), 64'h80);
    tick;
    chk_grp("g1", 2'd2, 32'h8, {32'd2, 32'd3});
    tick;
    chk_grp("g2", 2'd2, 32'h10, {32'd4, 32'd5});

    dec_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk_grp("stall", 2'd2, 32'h10, {32'd4, 32'd5});
    end
    check_eq("perf_stall", 64'(perf_stall), PERF_ON * 64'd5);
    check_eq("perf_empty", 64'(perf_empty), PERF_ON * 64'd5);

    // Redirect while waiting for line 0x80: its response must be dropped.
    dec_stall = 1'b0;
    check_eq("req80",      64'(line_req),  64'd1);
    check_eq("req80_addr", 64'(line_addr), 64'h80);
    line_ack = 1'b1;
    tick;
    line_ack = 1'b0;
    chk_grp("pre_redir", 2'd2, 32'h18, {32'd6, 32'd7});
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    tick;
    redirect = 1'b0;
    check_eq("redir_cnt",   64'(out_count), 64'd0);
    check_eq("redir_pc",    64'(out_pc),    64'h400);
    check_eq("disc_noreq",  64'(line_req),  64'd0);
    check_eq("disc_addr",   64'(line_addr), 64'h400);
    line_vld  = 1'b1;
    line_data = mk_line(32'h80);
    tick;
    line_vld = 1'b0;
    check_eq("stale_cnt",   64'(out_count), 64'd0);
    check_eq("req400",      64'(line_req),  64'd1);
    check_eq("req400_addr", 64'(line_addr), 64'h400);
    fill(32'h400);
    chk_grp("g400", 2'd2, 32'h400, {32'h100, 32'h101});
    check_eq("perf_redir", 64'(perf_redir), PERF_ON * 64'd1);

    // Redirect to the last word of a line with only that line present.
    dec_stall   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h17C;
    tick;
    redirect = 1'b0;
    check_eq("req100",      64'(line_req),  64'd1);
    check_eq("req100_addr", 64'(line_addr), 64'h100);
    fill(32'h100);
    chk_grp("g17c", 2'd1, 32'h17C, {32'h5F, 32'h0});
    check_eq("req180_addr", 64'(line_addr), 64'h180);
    dec_stall = 1'b0;
    line_ack  = 1'b1;
    tick;
    line_ack = 1'b0;
    check_eq("drained_cnt", 64'(out_count), 64'd0);
    check_eq("drained_pc",  64'(out_pc),    64'h180);
    dec_stall = 1'b1;
    line_vld  = 1'b1;
    line_data = mk_line(32'h180);
    tick;
    line_vld = 1'b0;
    chk_grp("g180", 2'd2, 32'h180, {32'h60, 32'h61});

    // Group crossing from line 0x0 into line 0x80.
    redirect    = 1'b1;
    redirect_pc = 32'h7E;
    tick;
    redirect = 1'b0;
    check_eq("req7c_addr", 64'(line_addr), 64'h0);
    fill(32'h0);
    chk_grp("g7c_half", 2'd1, 32'h7C, {32'h1F, 32'h0});
    fill(32'h80);
    chk_grp("g7c_cross", 2'd2, 32'h7C, {32'h1F, 32'h20});
    check_eq("full_noreq", 64'(line_req), 64'd0);
    dec_stall = 1'b0;
    tick;
    dec_stall = 1'b1;
    chk_grp("g84", 2'd2, 32'h84, {32'h21, 32'h22});
    check_eq("freed_req",      64'(line_req),  64'd1);
    check_eq("freed_req_addr", 64'(line_addr), 64'h100);

    // Asynchronous reset while a response is outstanding.
    line_ack = 1'b1;
    tick;
    line_ack = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("arst_req", 64'(line_req),  64'd0);
    check_eq("arst_cnt", 64'(out_count), 64'd0);
    check_eq("arst_pc",  64'(out_pc),    64'h0);
    tick;
    rst       = 1'b1;
    dec_stall = 1'b0;
    line_vld  = 1'b1;
    line_data = mk_line(32'h100);
    tick;
    line_vld = 1'b0;
    check_eq("post_rst_cnt",  64'(out_count), 64'd0);
    check_eq("post_rst_req",  64'(line_req),  64'd1);
    check_eq("post_rst_addr", 64'(line_addr), 64'h0);
    fill(32'h0);
    chk_grp("g_post_rst", 2'd2, 32'h0, {32'd0, 32'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
